div_seq: RTL
============

// Module: div_seq
// PURPOSE
//   Sequential unsigned divider; the inverse operation of the registered mul unit
//   beside the adder/mul/sub units in top. Restoring division, one quotient bit per
//   clock, start/busy/done handshake. Quotient and remainder are held until the next
//   accepted operation.
// PARAMETERS
//   WIDTH  4  operand, quotient and remainder width in bits (WIDTH >= 2)
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      request; sampled only in IDLE or DONE
//   div_in1      in   WIDTH  dividend, captured on the edge that accepts start
//   div_in2      in   WIDTH  divisor, captured on the edge that accepts start
//   busy         out  1      registered; 1 while state == RUN
//   done         out  1      registered; one-cycle pulse when results update
//   div_quo      out  WIDTH  quotient
//   div_rem      out  WIDTH  remainder
//   div_by_zero  out  1      1 if the last completed operation had divisor 0
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, div_quo, div_rem, div_by_zero all 0; internal
//     registers 0. Applies asynchronously at any time, including mid-RUN. Any
//     operation in flight is discarded and produces no done.
//   States:
//   - IDLE: start=1 -> latch operands, count=WIDTH, r=0, q=dividend.
//     Next state is RUN, or DONE if the divisor is 0.
//   - RUN: one iteration per edge; count decrements. On the edge where count
//     reaches 0, results are written and next state is DONE.
//   - DONE: done=1 for exactly this cycle. start=1 here is accepted as in IDLE
//     (back-to-back). Otherwise next state is IDLE.
//   Iteration (r is WIDTH+1 bits):
//   - r' = {r[WIDTH-1:0], q[WIDTH-1]}; q' = q << 1
//   - if r' >= {1'b0, d}: r' -= d and q'[0] = 1
//   Latency: start accepted at edge k.
//   - Normal: busy=1 after edges k..k+WIDTH-1. done=1 and results valid after
//     edge k+WIDTH (k+4 for WIDTH=4).
//   - Divisor 0: no RUN. done=1 after edge k+1; div_quo=all ones,
//     div_rem=dividend, div_by_zero=1.
//   - Normal completion writes div_by_zero=0.
//   start in RUN: ignored; operands are not re-sampled and the operation is unaffected.
//   Outputs div_quo, div_rem and div_by_zero change only on the edge that raises done.
//   They hold through IDLE and through the next RUN.
//   Invariant on normal completion: div_quo*div_in2 + div_rem == div_in1, div_rem < div_in2.
// TESTING
//   1. 13/3, start 1 cycle -> busy 4 cycles; done at k+4; quo=4, rem=1, dbz=0.
//   2. 15/1 then 3/9 (start held in DONE cycle) -> 15 r0, then 0 r3; second done at k2+4.
//   3. 7/0 -> done at k+1, busy never 1; quo=15, rem=7, dbz=1. Then 8/2 -> 4 r0, dbz=0.
//   4. 12/5, then start=1 with 1/1 during RUN -> ignored; result 2 r2; one done only.
//   5. 14/3, assert rst async after 2 RUN edges -> all outputs 0 immediately; no done.
//      Then 9/4 -> 2 r1.
//   6. All 256 (a,b) pairs, WIDTH=4 -> compare against a/b, a%b; b=0 per scenario 3.

Source files
------------

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Quotient, remainder and divide-by-zero flag hold until the next operation completes.
module div_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] div_in1,
  input  logic [WIDTH-1:0] div_in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_quo,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // StZero delays a divide-by-zero result by one cycle without entering RUN.
  typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [WIDTH-1:0]  quo_d, rem_d;
  logic              dbz_d;

  logic [WIDTH:0]    r_sh;
  logic              r_ge;
  logic [WIDTH-1:0]  r_it, q_it;

  // The partial remainder after a successful subtract is below d, so WIDTH bits suffice.
  always_comb begin
    r_sh = {r_q, q_q[WIDTH-1]};
    r_ge = (r_sh >= {1'b0, d_q});
    r_it = r_ge ? (r_sh[WIDTH-1:0] - d_q) : r_sh[WIDTH-1:0];
    q_it = {q_q[WIDTH-2:0], r_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = div_quo;
    rem_d   = div_rem;
    dbz_d   = div_by_zero;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          d_d     = div_in2;
          q_d     = div_in1;
          r_d     = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = (div_in2 == '0) ? StZero : StRun;
        end
      end
      StRun: begin
        r_d   = r_it;
        q_d   = q_it;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quo_d   = q_it;
          rem_d   = r_it;
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      StZero: begin
        quo_d   = '1;
        rem_d   = q_q;
        dbz_d   = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      div_quo     <= '0;
      div_rem     <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      div_quo     <= quo_d;
      div_rem     <= rem_d;
      div_by_zero <= dbz_d;
      busy        <= (state_d == StRun);
      done        <= (state_d == StDone);
    end
  end

endmodule
